bcedn_dc_scan_ctrl: RTL and testbench
=====================================

Name: bcedn_dc_scan_ctrl

Overview:
- Scan sequencer for the BCEDN decoder layer.
- Walks the padded, unpooled feature map in raster order. Decides each cycle whether the datapath takes a pad zero or a live unpooled pixel (pad_mux_sel).
- Issues pooled-index ROM reads and stalls on upstream data.
- Flags valid convolution windows (out_en) and pulses tg_next at end of frame to trigger the next stage.

Parameters:
- H, 4, pooled input map height
- W, 4, pooled input map width
- POOL_H, 2, unpooling factor, rows
- POOL_W, 2, unpooling factor, cols
- PAD, 1, zero-pad width on each border
- FH, 3, conv filter height
- FW, 3, conv filter width
- STRIDE_H, 1, conv vertical stride
- STRIDE_W, 1, conv horizontal stride
- P, 1, row spacing; P-1 idle gap cycles are inserted between rows (P>=1)
- INDEX_ADDR_WIDTH, $clog2(H*W), pindex ROM address width

Derived values: HP = H*POOL_H + 2*PAD; WP = W*POOL_W + 2*PAD; SUBW = $clog2(POOL_H*POOL_W).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin one frame; ignored while busy
- in_en  in  1  upstream pixel valid for the current interior position
- busy  out  1  frame in progress
- pad_mux_sel  out  1  current position is padding; datapath selects zero
- data_req  out  1  current position is interior; waiting for in_en
- pindex_rd  out  1  one-cycle pindex ROM read strobe
- pindex_rd_addr  out  INDEX_ADDR_WIDTH  pooled pixel address = pr*W + pc
- sub_pos  out  SUBW  unpooled sub-position = ((r-PAD)%POOL_H)*POOL_W + (c-PAD)%POOL_W
- row_cnt  out  $clog2(HP)  current row r
- col_cnt  out  $clog2(WP)  current column c
- out_en  out  1  window ending at the previous advanced position is valid
- tg_next  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset values: state=IDLE, all counters 0, every output 0. Reset mid-frame aborts immediately; no tg_next is issued.
- FSM states:
  - IDLE: start=1 -> SCAN at (0,0), busy=1 from the next cycle.
  - SCAN: on advance at c==WP-1 and r<HP-1 -> GAP if P>1, else (r+1, 0). On advance at (HP-1, WP-1) -> IDLE.
  - GAP: stays P-1 cycles, then SCAN at (r+1, 0).
- Pad position: r<PAD, r>=HP-PAD, c<PAD or c>=WP-PAD. Everything else is interior.
- pad_mux_sel and data_req:
  - Moore outputs, decoded from registered state and counters only.
  - Both are 0 outside SCAN and mutually exclusive in SCAN.
- Advance rule in SCAN:
  - Pad position: advances every cycle.
  - Interior position: advances only in a cycle with in_en=1.
  - in_en at a pad position, or in IDLE/GAP, is ignored.
- Counters:
  - pr = (r-PAD)/POOL_H and pc = (c-PAD)/POOL_W are kept as sub-counters; no dividers.
  - sub_pos is driven from those sub-counters.
  - row_cnt and col_cnt mirror r and c. In GAP they hold the last column of the row.
- pindex_rd:
  - Pulses exactly once, in the first cycle that an interior position with (c-PAD)%POOL_W==0 becomes current. No repeat while stalled.
  - pindex_rd_addr is valid in that same cycle.
  - Each pooled address is read POOL_H times per frame.
- out_en:
  - Registered, so it is high in the cycle after a qualifying advance.
  - Qualifying advance: r>=FH-1, c>=FW-1, (r-FH+1)%STRIDE_H==0 and (c-FW+1)%STRIDE_W==0.
  - Stride phases are kept as wrap counters.
- tg_next and busy:
  - tg_next is high in the cycle after the final advance.
  - busy drops in that same cycle.
  - start in the same cycle as tg_next is accepted.
- Widths: all comparisons are unsigned. pindex_rd_addr is zero-extended if the product is narrower than INDEX_ADDR_WIDTH.

Test Plan:
- Defaults, in_en held 1, start at cycle 0:
  - SCAN covers cycles 1..100; tg_next at cycle 101.
  - pad_mux_sel high for 36 cycles, data_req for 64.
  - out_en pulses 64, pindex_rd pulses 32.
  - Addresses 0,1,2,3,0,1,2,3,4,... with each pooled row pair repeated.
- P=3, otherwise defaults, in_en=1: 18 gap cycles (9 boundaries x 2); tg_next at cycle 119; no data_req or out_en during GAP.
- Stall at interior (1,1): in_en low for 5 cycles.
  - data_req stays high, row_cnt=1, col_cnt=1 and sub_pos=0 throughout.
  - pindex_rd pulses once with addr 0.
  - Frame completes 5 cycles later than the unstalled run.
- STRIDE_H=STRIDE_W=2, FH=FW=3: out_en pulses 16 times, at positions (2,2),(2,4),...,(8,8).
- rst asserted for 1 cycle mid-frame at (5,5):
  - All outputs 0 the next cycle, no tg_next.
  - A new start then produces a full 64-out_en frame.
- start pulsed while busy: ignored, no counter disturbance. start coincident with tg_next: new frame begins at (0,0) the next cycle.

Source files
------------

// File: rtl/bcedn_dc_scan_ctrl.sv
// Raster-scan sequencer for the BCEDN decoder layer: walks the padded, unpooled map,
// steers pad/live data, issues pooled-index reads and flags valid conv windows.
module bcedn_dc_scan_ctrl #(
  parameter int H                = 4,
  parameter int W                = 4,
  parameter int POOL_H           = 2,
  parameter int POOL_W           = 2,
  parameter int PAD              = 1,
  parameter int FH               = 3,
  parameter int FW               = 3,
  parameter int STRIDE_H         = 1,
  parameter int STRIDE_W         = 1,
  parameter int P                = 1,
  parameter int INDEX_ADDR_WIDTH = (H * W > 1) ? $clog2(H * W) : 1,
  localparam int HP   = H * POOL_H + 2 * PAD,
  localparam int WP   = W * POOL_W + 2 * PAD,
  localparam int RW   = (HP > 1) ? $clog2(HP) : 1,
  localparam int CW   = (WP > 1) ? $clog2(WP) : 1,
  localparam int SUBW = (POOL_H * POOL_W > 1) ? $clog2(POOL_H * POOL_W) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_en,
  output logic                        busy,
  output logic                        pad_mux_sel,
  output logic                        data_req,
  output logic                        pindex_rd,
  output logic [INDEX_ADDR_WIDTH-1:0] pindex_rd_addr,
  output logic [SUBW-1:0]             sub_pos,
  output logic [RW-1:0]               row_cnt,
  output logic [CW-1:0]               col_cnt,
  output logic                        out_en,
  output logic                        tg_next
);

  localparam int PRW  = (H > 1) ? $clog2(H) : 1;
  localparam int PCW  = (W > 1) ? $clog2(W) : 1;
  localparam int SRW  = (POOL_H > 1) ? $clog2(POOL_H) : 1;
  localparam int SCW  = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam int PHRW = (STRIDE_H > 1) ? $clog2(STRIDE_H) : 1;
  localparam int PHCW = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;
  localparam int GW   = (P > 2) ? $clog2(P - 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [PRW-1:0]  r_pr;
  logic [PCW-1:0]  r_pc;
  logic [SRW-1:0]  r_sr;
  logic [SCW-1:0]  r_sc;
  logic [PHRW-1:0] r_phr;
  logic [PHCW-1:0] r_phc;
  logic [GW-1:0]   r_gap;
  logic            r_fresh;
  logic            r_out_en;
  logic            r_tg_next;

  logic            w_pad;
  logic            w_adv;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_final;
  logic            w_gap_done;
  logic            w_row_step;
  logic            w_col_step;
  logic            w_start_acc;
  logic            w_win_ok;
  logic [RW-1:0]   w_row_nxt;
  logic [CW-1:0]   w_col_nxt;

  assign w_row_nxt   = r_row + RW'(1);
  assign w_col_nxt   = r_col + CW'(1);
  assign w_pad       = (r_row < RW'(PAD)) || (r_row >= RW'(HP - PAD)) ||
                       (r_col < CW'(PAD)) || (r_col >= CW'(WP - PAD));
  assign w_adv       = (r_state == ST_SCAN) && (w_pad || in_en);
  assign w_last_col  = (r_col == CW'(WP - 1));
  assign w_last_row  = (r_row == RW'(HP - 1));
  assign w_final     = w_adv && w_last_col && w_last_row;
  assign w_gap_done  = (r_state == ST_GAP) && (r_gap == GW'(P - 2));
  // With no gap the row turns over on the last-column advance; otherwise on gap exit.
  assign w_row_step  = ((P == 1) && w_adv && w_last_col && !w_last_row) || w_gap_done;
  assign w_col_step  = w_adv && !w_last_col;
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_win_ok    = (r_row >= RW'(FH - 1)) && (r_col >= CW'(FW - 1)) &&
                       (r_phr == PHRW'(0)) && (r_phc == PHCW'(0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SCAN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_SCAN: begin
        if (w_adv && w_last_col) begin
          if (w_last_row) w_state_nxt = ST_IDLE;
          else if (P > 1) w_state_nxt = ST_GAP;
          else            w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_GAP: begin
        if (w_gap_done) w_state_nxt = ST_SCAN;
        else            w_state_nxt = ST_GAP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state and counters
  always_comb begin
    busy        = 1'b0;
    pad_mux_sel = 1'b0;
    data_req    = 1'b0;
    pindex_rd   = 1'b0;
    case (r_state)
      ST_SCAN: begin
        busy        = 1'b1;
        pad_mux_sel = w_pad;
        data_req    = !w_pad;
        pindex_rd   = r_fresh && !w_pad && (r_sc == SCW'(0));
      end
      ST_GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Position, pooled sub-counters and stride phases
  always_ff @(posedge clk) begin
    if (rst || w_start_acc || w_final) begin
      r_row <= RW'(0);
      r_col <= CW'(0);
      r_pr  <= PRW'(0);
      r_pc  <= PCW'(0);
      r_sr  <= SRW'(0);
      r_sc  <= SCW'(0);
      r_phr <= PHRW'(0);
      r_phc <= PHCW'(0);
    end else if (w_row_step) begin
      r_row <= w_row_nxt;
      r_col <= CW'(0);
      r_pc  <= PCW'(0);
      r_sc  <= SCW'(0);
      r_phc <= PHCW'(0);
      if ((w_row_nxt <= RW'(PAD)) || (w_row_nxt >= RW'(HP - PAD))) begin
        r_pr <= PRW'(0);
        r_sr <= SRW'(0);
      end else if (r_sr == SRW'(POOL_H - 1)) begin
        r_pr <= r_pr + PRW'(1);
        r_sr <= SRW'(0);
      end else begin
        r_sr <= r_sr + SRW'(1);
      end
      if (w_row_nxt <= RW'(FH - 1))           r_phr <= PHRW'(0);
      else if (r_phr == PHRW'(STRIDE_H - 1))  r_phr <= PHRW'(0);
      else                                    r_phr <= r_phr + PHRW'(1);
    end else if (w_col_step) begin
      r_col <= w_col_nxt;
      if ((w_col_nxt <= CW'(PAD)) || (w_col_nxt >= CW'(WP - PAD))) begin
        r_pc <= PCW'(0);
        r_sc <= SCW'(0);
      end else if (r_sc == SCW'(POOL_W - 1)) begin
        r_pc <= r_pc + PCW'(1);
        r_sc <= SCW'(0);
      end else begin
        r_sc <= r_sc + SCW'(1);
      end
      if (w_col_nxt <= CW'(FW - 1))           r_phc <= PHCW'(0);
      else if (r_phc == PHCW'(STRIDE_W - 1))  r_phc <= PHCW'(0);
      else                                    r_phc <= r_phc + PHCW'(1);
    end
  end

  // Gap timer, read-once flag and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap     <= GW'(0);
      r_fresh   <= 1'b0;
      r_out_en  <= 1'b0;
      r_tg_next <= 1'b0;
    end else begin
      r_gap     <= (r_state == ST_GAP) ? (r_gap + GW'(1)) : GW'(0);
      r_fresh   <= w_start_acc || w_row_step || w_col_step;
      r_out_en  <= w_adv && w_win_ok;
      r_tg_next <= w_final;
    end
  end

  assign pindex_rd_addr = INDEX_ADDR_WIDTH'(r_pr) * INDEX_ADDR_WIDTH'(W) +
                          INDEX_ADDR_WIDTH'(r_pc);
  assign sub_pos        = SUBW'(r_sr) * SUBW'(POOL_W) + SUBW'(r_sc);
  assign row_cnt        = r_row;
  assign col_cnt        = r_col;
  assign out_en         = r_out_en;
  assign tg_next        = r_tg_next;

endmodule

// File: tb/tb_bcedn_dc_scan_ctrl.sv
// Directed bench for bcedn_dc_scan_ctrl: default, P=3 and stride-2 instances,
// stall, mid-frame reset and back-to-back start scenarios.
module tb_bcedn_dc_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_en;

  logic       d_busy, d_pad, d_req, d_rd, d_oe, d_tg;
  logic [3:0] d_addr, d_row, d_col;
  logic [1:0] d_sub;
  logic       p_busy, p_pad, p_req, p_rd, p_oe, p_tg;
  logic [3:0] p_addr, p_row, p_col;
  logic [1:0] p_sub;
  logic       s_busy, s_pad, s_req, s_rd, s_oe, s_tg;
  logic [3:0] s_addr, s_row, s_col;
  logic [1:0] s_sub;

  bcedn_dc_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en),
    .busy(d_busy), .pad_mux_sel(d_pad), .data_req(d_req), .pindex_rd(d_rd),
    .pindex_rd_addr(d_addr), .sub_pos(d_sub), .row_cnt(d_row), .col_cnt(d_col),
    .out_en(d_oe), .tg_next(d_tg)
  );

  bcedn_dc_scan_ctrl #(.P(3)) u_dut_p3 (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en),
    .busy(p_busy), .pad_mux_sel(p_pad), .data_req(p_req), .pindex_rd(p_rd),
    .pindex_rd_addr(p_addr), .sub_pos(p_sub), .row_cnt(p_row), .col_cnt(p_col),
    .out_en(p_oe), .tg_next(p_tg)
  );

  bcedn_dc_scan_ctrl #(.STRIDE_H(2), .STRIDE_W(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en),
    .busy(s_busy), .pad_mux_sel(s_pad), .data_req(s_req), .pindex_rd(s_rd),
    .pindex_rd_addr(s_addr), .sub_pos(s_sub), .row_cnt(s_row), .col_cnt(s_col),
    .out_en(s_oe), .tg_next(s_tg)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int s0 = 0;

  int d_busy_n, d_pad_n, d_req_n, d_oe_n, d_rd_n, d_tg_n, d_tg_rel;
  int p_pad_n, p_req_n, p_oe_n, p_gap_n, p_rd_n, p_tg_rel;
  int s_oe_n, s_tg_rel, s_prev;
  int d_addr_q[$];
  int s_pos_q[$];

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    d_busy_n = 0; d_pad_n = 0; d_req_n = 0; d_oe_n = 0; d_rd_n = 0; d_tg_n = 0; d_tg_rel = -1;
    p_pad_n = 0; p_req_n = 0; p_oe_n = 0; p_gap_n = 0; p_rd_n = 0; p_tg_rel = -1;
    s_oe_n = 0; s_tg_rel = -1; s_prev = -1;
    d_addr_q.delete();
    s_pos_q.delete();
  endtask

  // Drive one cycle of inputs, sample all outputs mid-cycle, advance to next cycle.
  task automatic step(input logic st, input logic ie, input logic rs);
    start = st; in_en = ie; rst = rs;
    @(negedge clk);
    if (d_busy) d_busy_n++;
    if (d_pad)  d_pad_n++;
    if (d_req)  d_req_n++;
    if (d_oe)   d_oe_n++;
    if (d_rd) begin d_rd_n++; d_addr_q.push_back(int'(d_addr)); end
    if (d_tg) begin d_tg_n++; d_tg_rel = cyc - s0; end
    if (p_pad) p_pad_n++;
    if (p_req) p_req_n++;
    if (p_oe)  p_oe_n++;
    if (p_rd)  p_rd_n++;
    if (p_busy && !p_pad && !p_req) p_gap_n++;
    if (p_tg) p_tg_rel = cyc - s0;
    if (s_oe) begin s_oe_n++; s_pos_q.push_back(s_prev); end
    if (s_tg) s_tg_rel = cyc - s0;
    s_prev = int'(s_row) * 16 + int'(s_col);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_busy"}, int'(d_busy), 0);
    chk_val({tag, "_pad"},  int'(d_pad),  0);
    chk_val({tag, "_req"},  int'(d_req),  0);
    chk_val({tag, "_rd"},   int'(d_rd),   0);
    chk_val({tag, "_addr"}, int'(d_addr), 0);
    chk_val({tag, "_sub"},  int'(d_sub),  0);
    chk_val({tag, "_row"},  int'(d_row),  0);
    chk_val({tag, "_col"},  int'(d_col),  0);
    chk_val({tag, "_oe"},   int'(d_oe),   0);
    chk_val({tag, "_tg"},   int'(d_tg),   0);
  endtask

  initial begin
    int k;
    int rd11;
    rst = 1'b1; start = 1'b0; in_en = 1'b0;
    clr_counts();
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk_all_zero("reset");

    // Frame 1: all three instances, in_en held high, start retried while busy
    clr_counts();
    s0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (int rel = 1; rel <= 125; rel++) step(rel == 30, 1'b1, 1'b0);
    chk_val("def_tg_cycle", d_tg_rel, 101);
    chk_val("def_tg_count", d_tg_n, 1);
    chk_val("def_busy_cycles", d_busy_n, 100);
    chk_val("def_pad_cycles", d_pad_n, 36);
    chk_val("def_req_cycles", d_req_n, 64);
    chk_val("def_out_en", d_oe_n, 64);
    chk_val("def_pindex_rd", d_rd_n, 32);
    k = 0;
    for (int pr = 0; pr < 4; pr++)
      for (int rep = 0; rep < 2; rep++)
        for (int pc = 0; pc < 4; pc++) begin
          chk_val($sformatf("def_addr[%0d]", k),
                  (k < d_addr_q.size()) ? d_addr_q[k] : -1, pr * 4 + pc);
          k++;
        end
    chk_val("p3_tg_cycle", p_tg_rel, 119);
    chk_val("p3_gap_cycles", p_gap_n, 18);
    chk_val("p3_pad_cycles", p_pad_n, 36);
    chk_val("p3_req_cycles", p_req_n, 64);
    chk_val("p3_out_en", p_oe_n, 64);
    chk_val("p3_pindex_rd", p_rd_n, 32);
    chk_val("s2_tg_cycle", s_tg_rel, 101);
    chk_val("s2_out_en", s_oe_n, 16);
    for (int j = 0; j < 16; j++)
      chk_val($sformatf("s2_pos[%0d]", j), (j < s_pos_q.size()) ? s_pos_q[j] : -1,
              (2 + 2 * (j / 4)) * 16 + (2 + 2 * (j % 4)));

    // Frame 2: stall at (1,1) for 5 cycles, then restart coincident with tg_next
    clr_counts();
    rd11 = 0;
    s0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (int rel = 1; rel <= 106; rel++) begin
      if (rel >= 12 && rel <= 16) begin
        chk_val($sformatf("stall_req@%0d", rel), int'(d_req), 1);
        chk_val($sformatf("stall_row@%0d", rel), int'(d_row), 1);
        chk_val($sformatf("stall_col@%0d", rel), int'(d_col), 1);
        chk_val($sformatf("stall_sub@%0d", rel), int'(d_sub), 0);
      end
      if (d_rd && d_row == 4'd1 && d_col == 4'd1) begin
        rd11++;
        chk_val("stall_rd_addr", int'(d_addr), 0);
      end
      if (rel == 106) begin
        chk_val("coinc_tg", int'(d_tg), 1);
        chk_val("coinc_busy_low", int'(d_busy), 0);
      end
      step(rel == 106, !(rel >= 12 && rel <= 16), 1'b0);
    end
    chk_val("stall_rd_once", rd11, 1);
    chk_val("stall_tg_cycle", d_tg_rel, 106);
    chk_val("stall_pindex_rd", d_rd_n, 32);
    chk_val("restart_busy", int'(d_busy), 1);
    chk_val("restart_row", int'(d_row), 0);
    chk_val("restart_col", int'(d_col), 0);
    chk_val("restart_pad", int'(d_pad), 1);

    // Frame 3: reset asserted for one cycle at (5,5)
    clr_counts();
    s0 = cyc - 1;
    for (int rel = 1; rel <= 55; rel++) step(1'b0, 1'b1, 1'b0);
    chk_val("abort_row", int'(d_row), 5);
    chk_val("abort_col", int'(d_col), 5);
    step(1'b0, 1'b1, 1'b1);
    chk_all_zero("abort");
    clr_counts();
    for (int rel = 0; rel < 150; rel++) step(1'b0, 1'b1, 1'b0);
    chk_val("abort_no_tg", d_tg_n, 0);
    chk_val("abort_idle", d_busy_n, 0);

    // Frame 4: clean frame after the abort
    clr_counts();
    s0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (int rel = 1; rel <= 125; rel++) step(1'b0, 1'b1, 1'b0);
    chk_val("post_abort_out_en", d_oe_n, 64);
    chk_val("post_abort_tg_cycle", d_tg_rel, 101);
    chk_val("post_abort_tg_count", d_tg_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
